// File: rtl/tff_counter_ctrl.sv
// Sequencer for a bank of T flip-flop stages forming a programmable modulo
// up/down counter with run control, one-shot mode, synchronous load and done.
module tff_counter_ctrl #(
   parameter int          WIDTH       = 4,
   parameter int unsigned DEFAULT_MOD = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             up_dn,
   input  logic             one_shot,
   input  logic [WIDTH-1:0] mod_val,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] t_vec,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] mod_q;
   logic             os_q;

   logic             running;
   logic [WIDTH-1:0] eff_mod;
   logic [WIDTH-1:0] m_last;
   logic             load_ok;
   logic             at_wrap;

   // The latched modulus governs a run; outside a run the live input does,
   // so loads in IDLE/DONE clamp against what the next run would use.
   assign running = (state_q == ST_RUN);
   assign eff_mod = running ? mod_q : mod_val;
   assign m_last  = eff_mod - WIDTH'(1);           // 0 wraps to all-ones = 2^WIDTH-1
   assign load_ok = (eff_mod == '0) || (load_val < eff_mod);
   assign at_wrap = up_dn ? (q_q == m_last) : (q_q == '0);

   assign tc = running && !stop && !load && at_wrap;

   always_comb begin
      // NOTE: default first so every path assigns q_d and no latch is inferred.
      q_d = q_q;
      if (load) begin
         q_d = load_ok ? load_val : '0;
      end else if (running && !stop) begin
         if (up_dn) q_d = at_wrap ? '0     : q_q + WIDTH'(1);
         else       q_d = at_wrap ? m_last : q_q - WIDTH'(1);
      end
   end

   assign t_vec = q_q ^ q_d;

   // T stages: each bit toggles where its enable is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         q_q <= q_q ^ t_vec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mod_q   <= WIDTH'(DEFAULT_MOD);
         os_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !stop) begin
                  state_q <= ST_RUN;
                  mod_q   <= mod_val;
                  os_q    <= one_shot;
               end
            end
            ST_RUN: begin
               if (stop)             state_q <= ST_IDLE;
               else if (tc && os_q)  state_q <= ST_DONE;
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign q    = q_q;
   assign busy = running;
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Randomised and directed stimulus for tff_counter_ctrl; expected outputs come
// from an integer reference model and are checked via a scoreboard queue.
module tb_tff_counter_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, stop, up_dn, one_shot, load;
   logic [W-1:0] mod_val, load_val;
   logic [W-1:0] t_vec, q;
   logic         tc, busy, done;

   tff_counter_ctrl #(.WIDTH(W), .DEFAULT_MOD(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .up_dn(up_dn),
      .one_shot(one_shot), .mod_val(mod_val), .load(load), .load_val(load_val),
      .t_vec(t_vec), .q(q), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int q;
      int tvec;
      bit tc;
      bit busy;
      bit done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: plain integers and flags.
   int m_q;
   bit m_run, m_done, m_os;
   int m_mod;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q = 0; m_run = 0; m_done = 0; m_os = 0; m_mod = 10;
   endtask

   // One cycle: drive inputs after the edge, push expected outputs, advance model.
   task automatic step(input bit st, input bit sp, input bit up, input bit os,
                       input int md, input bit ld, input int lv);
      exp_t e;
      int   eff, m, nq;
      bit   t;
      @(posedge clk);
      #1;
      start = st; stop = sp; up_dn = up; one_shot = os;
      mod_val = W'(md); load = ld; load_val = W'(lv);
      eff = m_run ? m_mod : md;
      m   = (eff == 0) ? 16 : eff;
      t   = m_run && !sp && !ld && (up ? (m_q == m - 1) : (m_q == 0));
      if (ld)                nq = (lv < m) ? lv : 0;
      else if (m_run && !sp) nq = up ? ((m_q == m - 1) ? 0 : (m_q + 1) % 16)
                                     : ((m_q == 0) ? m - 1 : m_q - 1);
      else                   nq = m_q;
      e.q = m_q; e.tvec = m_q ^ nq; e.tc = t; e.busy = m_run; e.done = m_done;
      sb.push_back(e);
      m_q = nq;
      if (m_run) begin
         if (sp) m_run = 0;
         else if (t && m_os) begin m_run = 0; m_done = 1; end
      end else if (m_done) begin
         m_done = 0;
      end else if (st && !sp) begin
         m_run = 1; m_mod = md; m_os = os;
      end
   endtask

   task automatic idle_cycles(input int n, input int md);
      for (int i = 0; i < n; i++) step(0, 0, 1, 0, md, 0, 0);
   endtask

   // Monitor: compares whatever the DUT presents mid-cycle against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q",     int'(q),     e.q);
            check("t_vec", int'(t_vec), e.tvec);
            check("tc",    int'(tc),    int'(e.tc));
            check("busy",  int'(busy),  int'(e.busy));
            check("done",  int'(done),  int'(e.done));
         end
      end
   end

   task automatic async_reset();
      @(negedge clk);
      #1;
      start = 0; stop = 0; load = 0; one_shot = 0;
      rst_n = 1'b0;
      #1;
      check("rst_q",    int'(q),    0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_tc",   int'(tc),   0);
      model_reset();
      #10;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      start = 0; stop = 0; up_dn = 1; one_shot = 0; load = 0;
      mod_val = 4'd10; load_val = 4'd0;
      #2;
      rst_n = 1'b0;
      #1;
      check("init_rst_q",    int'(q),    0);
      check("init_rst_busy", int'(busy), 0);
      check("init_rst_done", int'(done), 0);
      check("init_rst_tc",   int'(tc),   0);
      model_reset();
      #20;
      rst_n = 1'b1;
      idle_cycles(5, 10);

      // Up mod 10 free-run through a wrap.
      step(1, 0, 1, 0, 10, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 10, 0, 0);
      step(0, 1, 1, 0, 10, 0, 0);

      // Down over the full range from 0.
      step(0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);

      // One-shot mod 4 from 0: DONE for one cycle, then hold.
      step(0, 0, 1, 0, 4, 1, 0);
      step(1, 0, 1, 1, 4, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 4, 0, 0);

      // Load priority and clamp while running mod 10.
      step(0, 0, 1, 0, 10, 1, 0);
      step(1, 0, 1, 0, 10, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 10, 0, 0);
      step(0, 0, 1, 0, 10, 1, 7);
      step(0, 0, 1, 0, 10, 0, 0);
      step(0, 0, 1, 0, 10, 1, 12);
      step(0, 0, 1, 0, 10, 0, 0);
      step(0, 1, 1, 0, 10, 1, 3);
      idle_cycles(2, 10);

      // Start with stop in IDLE stays idle.
      step(1, 1, 1, 0, 10, 0, 0);
      idle_cycles(2, 10);

      // Stop exactly at terminal count in one-shot: no done pulse.
      step(0, 0, 1, 0, 4, 1, 0);
      step(1, 0, 1, 1, 4, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4, 0, 0);
      step(0, 1, 1, 0, 4, 0, 0);
      idle_cycles(3, 4);

      // Reset in the middle of a run.
      step(1, 0, 1, 0, 10, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 10, 0, 0);
      async_reset();
      idle_cycles(3, 10);

      // Randomised traffic, including modulus changes with q >= M.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)), $urandom_range(0, 11) == 0,
              int'($urandom_range(0, 15)));
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tff_counter_ctrl.md
Name: tff_counter_ctrl

Overview:
Sequencer for a bank of WIDTH toggle flip-flop stages forming a programmable modulo up/down counter. Each cycle the controller computes the per-stage toggle vector t_vec and applies it to its internal T stages, so q[i] <= q[i] ^ t_vec[i]. Provides start/stop run control, one-shot mode, synchronous load, terminal-count indication and done. Sits between control logic and the T flip-flop datapath as the block that sequences the stages.

Parameters:
WIDTH, 4, number of T stages / counter width
DEFAULT_MOD, 10, modulus held in mod_reg after reset (0 means 2^WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin counting; latches mod_val and one_shot
stop  input  1  abort run, return to IDLE
up_dn  input  1  1 = count up, 0 = count down; sampled every cycle
one_shot  input  1  1 = finish after first wrap; latched at start
mod_val  input  WIDTH  modulus; 0 = 2^WIDTH
load  input  1  synchronous load request
load_val  input  WIDTH  value to load
t_vec  output  WIDTH  toggle enables applied at the coming edge (combinational)
q  output  WIDTH  current stage states (registered)
tc  output  1  terminal count: wrap occurs at the coming edge (combinational)
busy  output  1  high in RUN
done  output  1  one-cycle pulse, high in DONE

Behaviour:
- Reset (rst_n low, asynchronous): q=0, state=IDLE, mod_reg=DEFAULT_MOD, os_reg=0. Hence busy=0, done=0, tc=0, and t_vec=0 unless load is asserted.
- Effective modulus M: mod_reg in RUN, mod_val in IDLE/DONE. A value of 0 means 2^WIDTH. All arithmetic is modulo 2^WIDTH.
- Stage update: q <= q ^ t_vec every edge. t_vec = q ^ next_q, and t_vec = 0 whenever next_q == q.
- next_q priority, highest first:
  1. load: next_q = load_val if load_val < M, else 0. Accepted in any state.
  2. RUN, not stop: up gives (q == M-1) ? 0 : q+1. Down gives (q == 0) ? M-1 : q-1.
  3. Otherwise: next_q = q.
- tc = (state==RUN) && !stop && !load && (q == M-1 for up, q == 0 for down).
- If q >= M while running (after a modulus change via a new start), up-count still wraps only at M-1. Up with q > M-1 increments modulo 2^WIDTH until q reaches M-1; down behaves normally.
- FSM:
  - IDLE: start=1 and stop=0 -> RUN; mod_reg <= mod_val, os_reg <= one_shot. q is not reset on start. Start with stop both high stays IDLE.
  - RUN: stop=1 -> IDLE (stop beats tc). tc=1 and os_reg=1 -> DONE. Otherwise stay RUN. start in RUN is ignored.
  - DONE: lasts exactly one cycle, then IDLE. start in DONE is ignored. load is still honoured.
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so there is no combinational path to inputs.
- Latency: start seen at edge k -> busy high after edge k; first toggle applied at edge k+1.
- one_shot wrap: the wrap edge moves q to the wrap value and the state to DONE together. done is high for the following cycle.
- up_dn change mid-run takes effect at the next edge. No glitch requirement on t_vec.
- Reset asserted mid-run returns to IDLE with q=0 immediately, without waiting for clk. Release is synchronous to the next edge.

Test Plan:
- Reset then IDLE: assert rst_n=0 mid-cycle -> q=0, busy=0, done=0, tc=0 with no clock edge; hold IDLE 5 cycles with no load -> t_vec=0, q stays 0.
- Up mod 10 free-run: mod_val=10, up_dn=1, one_shot=0, pulse start -> q steps 0,1,...,9,0,1. tc high only while q=9. At the 9->0 edge t_vec=4'b1001.
- Down, full range: mod_val=0, up_dn=0, start from q=0 -> next q=15 (t_vec=4'b1111), then 14. tc high while q=0.
- One-shot: mod_val=4, one_shot=1, up, start at q=0 -> q 1,2,3,0. State moves to DONE on the 3->0 edge, done=1 for exactly one cycle, then busy=0 and q holds 0.
- Load priority and clamp:
  - In RUN at q=5 (mod 10), load=1, load_val=7 -> q=7 next edge, tc=0 that cycle.
  - load_val=12 -> q=0.
  - load together with stop -> q=load value and state IDLE.
- Simultaneous and abort cases:
  - start with stop both high in IDLE -> stays IDLE.
  - stop asserted while tc=1 in one-shot -> IDLE, no done pulse, q unchanged.
  - rst_n low during RUN -> q=0, IDLE asynchronously.
